// File: rtl/drum_step_sequencer_pkg.sv
// Shared types for the drum machine: sequencer mode encoding used by
// the controller, the display and the step sequencer.
package drum_pkg;

    typedef enum logic [1:0] {
        EDIT = 2'b00,
        PLAY = 2'b01,
        RAW  = 2'b10
    } mode_e;

endpackage

// File: rtl/drum_step_sequencer_if.sv
// Keypad-side commands and sample-player-side outputs of the step
// sequencer, bundled for the controller (master) and sequencer (slave).
interface drum_step_sequencer_if
    import drum_pkg::*;
#(
    parameter int NUM_CH    = 4,
    parameter int NUM_STEPS = 8,
    parameter int CNT_W     = 20
) ();

    localparam int IDX_W = $clog2(NUM_STEPS);

    logic                          set_edit;
    logic                          set_play;
    logic                          set_raw;
    logic                          cur_left;
    logic                          cur_right;
    logic [NUM_CH-1:0]             tgl;
    logic                          clr_all;
    logic [CNT_W-1:0]              step_period;
    logic [CNT_W-1:0]              gate_len;
    logic [NUM_CH-1:0]             raw_in;

    mode_e                         mode;
    logic [IDX_W-1:0]              step_idx;
    logic [NUM_STEPS-1:0]          step_onehot;
    logic                          step_tick;
    logic [NUM_CH-1:0]             gate;
    logic [NUM_STEPS*NUM_CH-1:0]   pattern;

    modport master (
        output set_edit, set_play, set_raw,
        output cur_left, cur_right,
        output tgl, clr_all,
        output step_period, gate_len, raw_in,
        input  mode, step_idx, step_onehot,
        input  step_tick, gate, pattern
    );

    modport slave (
        input  set_edit, set_play, set_raw,
        input  cur_left, cur_right,
        input  tgl, clr_all,
        input  step_period, gate_len, raw_in,
        output mode, step_idx, step_onehot,
        output step_tick, gate, pattern
    );

endinterface

// File: rtl/drum_step_sequencer_step_timer.sv
// Step-period counter: terminal-count detection and the look-ahead
// gate window for the value the counter takes at the next edge.
module step_timer #(
    parameter int CNT_W = 20
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             run,
    input  logic             restart,
    input  logic [CNT_W-1:0] period,
    input  logic [CNT_W-1:0] gate_len,
    output logic             adv,
    output logic             win_n
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_n;
    logic [CNT_W-1:0] last;

    // ">=" rather than "==" so a period shortened mid-step still
    // terminates on the next cycle instead of running to wrap-around.
    always_comb begin
        last  = (period == '0) ? '0 : period - CNT_W'(1);
        adv   = run & ~restart & (cnt_q >= last);
        cnt_n = cnt_q + CNT_W'(1);
        if (!run || restart || adv) begin
            cnt_n = '0;
        end
        win_n = (cnt_n < gate_len);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_n;
        end
    end

endmodule

// File: rtl/drum_step_sequencer.sv
// Drum step sequencer: pattern memory, edit cursor and mode FSM, with
// every output registered from the next-state values.
module drum_step_sequencer
    import drum_pkg::*;
#(
    parameter int NUM_CH    = 4,
    parameter int NUM_STEPS = 8,
    parameter int CNT_W     = 20
) (
    input logic                  clk,
    input logic                  rst_n,
    drum_step_sequencer_if.slave bus
);

    localparam int IDX_W = $clog2(NUM_STEPS);
    localparam int PAT_W = NUM_STEPS * NUM_CH;
    localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_STEPS - 1);

    mode_e                mode_q;
    mode_e                mode_n;
    logic [IDX_W-1:0]     cur_q;
    logic [IDX_W-1:0]     cur_n;
    logic [IDX_W-1:0]     pidx_q;
    logic [IDX_W-1:0]     pidx_n;
    logic [PAT_W-1:0]     pat_q;
    logic [PAT_W-1:0]     pat_n;
    logic [IDX_W-1:0]     eidx;

    logic [IDX_W-1:0]     idx_q;
    logic [IDX_W-1:0]     idx_n;
    logic [NUM_STEPS-1:0] oh_q;
    logic [NUM_STEPS-1:0] oh_n;
    logic                 tick_q;
    logic                 tick_n;
    logic [NUM_CH-1:0]    gate_q;
    logic [NUM_CH-1:0]    gate_n;
    logic [NUM_CH-1:0]    row;

    logic                 play_req;
    logic                 run;
    logic                 adv;
    logic                 win_n;

    assign play_req = bus.set_play & ~bus.set_edit;
    assign run      = (mode_n == PLAY);

    step_timer #(
        .CNT_W    (CNT_W)
    ) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .run      (run),
        .restart  (play_req),
        .period   (bus.step_period),
        .gate_len (bus.gate_len),
        .adv      (adv),
        .win_n    (win_n)
    );

    always_comb begin
        mode_n = mode_q;
        if (bus.set_edit) begin
            mode_n = EDIT;
        end else if (bus.set_play) begin
            mode_n = PLAY;
        end else if (bus.set_raw) begin
            mode_n = RAW;
        end
    end

    always_comb begin
        cur_n = cur_q;
        if (mode_q == EDIT && (bus.cur_left ^ bus.cur_right)) begin
            if (bus.cur_right) begin
                cur_n = (cur_q == LAST) ? '0 : cur_q + IDX_W'(1);
            end else begin
                cur_n = (cur_q == '0) ? LAST : cur_q - IDX_W'(1);
            end
        end
    end

    // Toggles land on the play position while playing (live record),
    // otherwise on the edit cursor.
    always_comb begin
        eidx  = (mode_q == PLAY) ? pidx_q : cur_q;
        pat_n = pat_q;
        if (bus.clr_all) begin
            pat_n = '0;
        end else begin
            pat_n[eidx*NUM_CH +: NUM_CH] = pat_q[eidx*NUM_CH +: NUM_CH] ^ bus.tgl;
        end
    end

    always_comb begin
        pidx_n = pidx_q;
        if (play_req) begin
            pidx_n = '0;
        end else if (adv) begin
            pidx_n = (pidx_q == LAST) ? '0 : pidx_q + IDX_W'(1);
        end
        tick_n = run & (play_req | adv);
    end

    always_comb begin
        row    = pat_n[pidx_n*NUM_CH +: NUM_CH];
        idx_n  = '0;
        gate_n = '0;
        unique case (mode_n)
            EDIT: begin
                idx_n = cur_n;
            end
            PLAY: begin
                idx_n  = pidx_n;
                gate_n = (row & {NUM_CH{win_n}}) | bus.raw_in;
            end
            RAW: begin
                gate_n = bus.raw_in;
            end
            default: begin
                idx_n = '0;
            end
        endcase
        oh_n = (mode_n == RAW) ? '0 : (NUM_STEPS'(1) << idx_n);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q <= EDIT;
            cur_q  <= '0;
            pidx_q <= '0;
            pat_q  <= '0;
            idx_q  <= '0;
            oh_q   <= NUM_STEPS'(1);
            tick_q <= 1'b0;
            gate_q <= '0;
        end else begin
            mode_q <= mode_n;
            cur_q  <= cur_n;
            pidx_q <= pidx_n;
            pat_q  <= pat_n;
            idx_q  <= idx_n;
            oh_q   <= oh_n;
            tick_q <= tick_n;
            gate_q <= gate_n;
        end
    end

    assign bus.mode        = mode_q;
    assign bus.step_idx    = idx_q;
    assign bus.step_onehot = oh_q;
    assign bus.step_tick   = tick_q;
    assign bus.gate        = gate_q;
    assign bus.pattern     = pat_q;

endmodule

// File: doc/drum_step_sequencer.md
# drum_step_sequencer

Parametrised step sequencer core for the drum machine. Holds a NUM_STEPS × NUM_CH trigger pattern, runs edit/play/raw modes, and generates per-channel gate levels for the sample players. All timing derives from one system clock and a programmable step period, so tempo changes need no clock divider. Sits between the keypad decoder and the sample/mixer path.

## Interface
- NUM_CH, 4, drum channels (sample players driven)
- NUM_STEPS, 8, pattern steps per bar; ≥2
- CNT_W, 20, width of step-period and gate-length counters
- IDX_W, $clog2(NUM_STEPS), step index width (derived, not overridden)

- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- set_edit / set_play / set_raw  in  1 each  single-cycle mode-request pulses
- cur_left / cur_right  in  1 each  single-cycle edit-cursor move pulses
- tgl  in  NUM_CH  single-cycle per-channel toggle pulses
- clr_all  in  1  single-cycle pattern clear
- step_period  in  CNT_W  clk cycles per step; 0 treated as 1
- gate_len  in  CNT_W  clk cycles gate stays high within a step
- raw_in  in  NUM_CH  live pads, level
- mode  out  2  current mode (drum_pkg::mode_e)
- step_idx  out  IDX_W  cursor (EDIT) or play position (PLAY); 0 in RAW
- step_onehot  out  NUM_STEPS  one-hot of step_idx; all-zero in RAW
- step_tick  out  1  one-cycle pulse on every play-step advance
- gate  out  NUM_CH  per-channel gate to sample players
- pattern  out  NUM_STEPS*NUM_CH  flattened pattern, step s at [s*NUM_CH +: NUM_CH]

## Operation
- Mode FSM states EDIT, PLAY, RAW; reset → EDIT. Any set_* pulse moves to that mode from any mode (self-transition legal). Simultaneous requests: edit > play > raw.
- EDIT: cursor moves on cur_left (−1) / cur_right (+1), wrapping 0↔NUM_STEPS−1; both in same cycle → no move. Cursor persists across mode changes. tgl XORs pattern[cursor]. gate = 0.
- PLAY entry (including PLAY→PLAY): play index ← 0, timer ← 0, step_tick pulses. Timer counts 0..max(step_period,1)−1; on terminal count: index +1 (wrap to 0), timer ← 0, step_tick pulse. tgl XORs pattern[play index] (live record). cur_* ignored.
- PLAY gate[c] = (pattern[idx][c] & (timer < gate_len)) | raw_in[c]. gate_len ≥ step_period → continuous gate; gate_len = 0 → pattern gates never fire.
- RAW: gate = raw_in; tgl applies at cursor as in EDIT; timer held at 0.
- clr_all zeroes all pattern bits in any mode; beats tgl in the same cycle.
- step_period changed mid-step: new value used from next compare; if timer already ≥ new period−1, advance on next cycle.

## Timing
- All outputs registered; reset values: mode=EDIT, step_idx=0, step_onehot=1, step_tick=0, gate=0, pattern=0.
- Input pulse at edge N → state/pattern updated at edge N; outputs reflect it after edge N+1 at latest (one-cycle latency, gate included).
- Step advance: step_tick high for exactly the cycle in which step_idx shows new index; step_idx and step_onehot change together.
- Step length exactly max(step_period,1) cycles; no drift over wrap.
- rst_n asserted mid-play: all state to reset values immediately, pattern lost.

## Structure
- drum_pkg: mode_e enum (EDIT=2'b00, PLAY=2'b01, RAW=2'b10), shared by controller, display and this block.
- Sub-module step_timer (period/terminal-count/gate-window counter, CNT_W param); pattern storage, cursor and FSM in top of block.

## Test plan
- Reset, NUM_STEPS=8: cur_left once → step_idx=7, step_onehot=8'h80; cur_right twice → step_idx=1.
- EDIT cursor 2, tgl=4'b0101 → pattern[11:8]=4'b0101; tgl=4'b0001 again → 4'b0100; tgl+clr_all same cycle → pattern=0.
- Pattern step0=4'b1000, step_period=10, gate_len=3, set_play → gate[3] high 3 cycles, low 7; step_tick every 10 cycles; index wraps 7→0.
- set_edit and set_play same cycle → mode=EDIT; PLAY re-requested mid-step → index 0, step_tick pulse.
- RAW: raw_in=4'b0010 → gate=4'b0010 next cycle, step_onehot=0; step_period=0 in PLAY → advance every cycle.
- rst_n low mid-PLAY at step 5 → mode=EDIT, gate=0, pattern=0 without clock edge.
